// File: rtl/hmmm_pkg.sv
// ---------------------------------------------------------------------------
// hmmm_pkg
// Shared definitions for the Hmmm core program-counter slice.
//   HMMM_ADDR_W / HMMM_DATA_W : default PC and bus widths
//   op_e                      : the single operation the PC performs in a cycle,
//                               produced by the priority encoder in pc_stack
// ---------------------------------------------------------------------------
package hmmm_pkg;

    localparam int HMMM_ADDR_W = 8;
    localparam int HMMM_DATA_W = 16;

    // Listed from "do nothing" through the requests in falling priority order.
    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_CALL   = 3'd2,
        OP_RET    = 3'd3,
        OP_BRANCH = 3'd4,
        OP_INC    = 3'd5
    } op_e;

endpackage

// File: rtl/ret_stack.sv
// ---------------------------------------------------------------------------
// ret_stack
// Hardware return-address stack (LIFO) for call/return.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears the pointer only)
//   push       : write push_data at the current pointer and advance it
//   pop        : retreat the pointer, discarding the top entry
//   push_data  : return address to store
//   top        : entry that a pop would return (don't-care while empty)
//   sp         : occupancy, 0..DEPTH
//   full/empty : sp == DEPTH / sp == 0
// A push while full or a pop while empty is ignored here; the caller decides
// what that means for its error flags.
// ---------------------------------------------------------------------------
module ret_stack
    import hmmm_pkg::*;
#(
    parameter int WIDTH = HMMM_ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               push_data,
    output logic [WIDTH-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0]     sp,
    output logic                           full,
    output logic                           empty
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    // A one-entry stack still needs a one-bit index to address its array.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic [SP_W-1:0]  sp_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (sp_q == SP_MAX);
    assign empty   = (sp_q == '0);
    assign sp      = sp_q;

    // The pointer always names the next free slot, so the top of stack sits
    // one below it.
    assign wr_idx  = IDX_W'(sp_q);
    assign top_idx = IDX_W'(sp_q - SP_ONE);
    assign top     = empty ? '0 : mem_q[top_idx];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty && !push;

    // Next pointer value: only a legal push or pop moves it.
    always_comb begin
        sp_d = sp_q;
        if (do_push) begin
            sp_d = sp_q + SP_ONE;
        end else if (do_pop) begin
            sp_d = sp_q - SP_ONE;
        end
    end

    // Pointer register; reset empties the stack without touching the storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage array; contents are don't-care after reset so it has no reset.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// ---------------------------------------------------------------------------
// pc_stack
// Program counter for the Hmmm core with PC-relative branch, a hardware
// return stack and sticky stack-error flags. Sits on the shared tri-state bus.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pc_out       : drive {zeros, pc} onto data this cycle (combinational)
//   jump         : pc <= data[ADDR_W-1:0]
//   call         : push pc+1, then pc <= data[ADDR_W-1:0]
//   ret          : pc <= popped return address
//   branch       : pc <= pc + signed data[ADDR_W-1:0]
//   increment    : pc <= pc + 1
//   clr_err      : clear overflow/underflow (a simultaneous new error wins)
//   data         : shared bus, released (high-Z) unless pc_out is high
//   sp           : return-stack occupancy
//   stack_full   : sp == STACK_DEPTH
//   stack_empty  : sp == 0
//   overflow     : sticky, call attempted while full
//   underflow    : sticky, ret attempted while empty
// Only one operation happens per cycle: jump > call > ret > branch > increment.
// ---------------------------------------------------------------------------
module pc_stack
    import hmmm_pkg::*;
#(
    parameter int ADDR_W      = HMMM_ADDR_W,
    parameter int DATA_W      = HMMM_DATA_W,
    parameter int STACK_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pc_out,
    input  logic                              jump,
    input  logic                              call,
    input  logic                              ret,
    input  logic                              branch,
    input  logic                              increment,
    input  logic                              clr_err,
    inout  wire  [DATA_W-1:0]                 data,
    output logic [$clog2(STACK_DEPTH+1)-1:0]  sp,
    output logic                              stack_full,
    output logic                              stack_empty,
    output logic                              overflow,
    output logic                              underflow
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              underflow_q;
    logic              underflow_d;

    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] ret_addr;
    logic [ADDR_W-1:0] stack_top;
    logic              push;
    logic              pop;
    logic              unused_bus_bits;
    op_e               op;

    // The bus is read only through its low ADDR_W bits; the rest is ignored.
    assign operand         = data[ADDR_W-1:0];
    assign unused_bus_bits = ^data;
    assign ret_addr        = pc_q + ADDR_W'(1);

    // Bus drive is combinational so a reader sees the current pc this cycle.
    assign data = pc_out ? DATA_W'(pc_q) : {DATA_W{1'bz}};

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Priority encoder: the highest-priority request becomes the only
    // operation this cycle, everything below it is dropped.
    always_comb begin
        op = OP_NONE;
        if (jump) begin
            op = OP_JUMP;
        end else if (call) begin
            op = OP_CALL;
        end else if (ret) begin
            op = OP_RET;
        end else if (branch) begin
            op = OP_BRANCH;
        end else if (increment) begin
            op = OP_INC;
        end
    end

    // Next-state for pc, the error flags and the stack handshake. The clear
    // is applied first so a same-cycle error event overrides it. A call while
    // full or a ret while empty leaves pc alone and only raises its flag.
    // Branch relies on modular addition: adding the ADDR_W-bit two's
    // complement offset and discarding the carry gives the signed result.
    always_comb begin
        pc_d        = pc_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        push        = 1'b0;
        pop         = 1'b0;

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        case (op)
            OP_JUMP: begin
                pc_d = operand;
            end
            OP_CALL: begin
                if (!stack_full) begin
                    push = 1'b1;
                    pc_d = operand;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            OP_RET: begin
                if (!stack_empty) begin
                    pop  = 1'b1;
                    pc_d = stack_top;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            OP_BRANCH: begin
                pc_d = pc_q + operand;
            end
            OP_INC: begin
                pc_d = ret_addr;
            end
            default: begin
            end
        endcase
    end

    // PC and sticky flag registers; reset overrides any request this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top       (stack_top),
        .sp        (sp),
        .full      (stack_full),
        .empty     (stack_empty)
    );

endmodule

// File: tb/tb_pc_stack.sv
// ---------------------------------------------------------------------------
// tb_pc_stack
// Self-checking bench for pc_stack (ADDR_W=8, DATA_W=16, STACK_DEPTH=4).
// Each test task queues the state it expects after every operation, drives
// the operation for one clock, then reads pc back over the bus (pc_out=1)
// together with the status outputs and compares against the queued entry.
// ---------------------------------------------------------------------------
module tb_pc_stack;

    localparam logic [6:0] S_RST = 7'b1000000;
    localparam logic [6:0] S_JMP = 7'b0100000;
    localparam logic [6:0] S_CAL = 7'b0010000;
    localparam logic [6:0] S_RET = 7'b0001000;
    localparam logic [6:0] S_BR  = 7'b0000100;
    localparam logic [6:0] S_INC = 7'b0000010;
    localparam logic [6:0] S_CLR = 7'b0000001;
    localparam logic [6:0] S_NOP = 7'b0000000;

    typedef struct packed {
        logic [15:0] bus;
        logic [2:0]  sp;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
    } obs_t;

    typedef struct packed {
        logic [6:0]  ops;
        logic [15:0] d;
        obs_t        e;
    } step_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_out;
    logic        jump;
    logic        call;
    logic        ret;
    logic        branch;
    logic        increment;
    logic        clr_err;
    logic        tb_drive;
    logic [15:0] tb_data;
    wire  [15:0] data;
    logic [2:0]  sp;
    logic        stack_full;
    logic        stack_empty;
    logic        overflow;
    logic        underflow;

    obs_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    assign data = tb_drive ? tb_data : {16{1'bz}};

    pc_stack #(
        .ADDR_W      (8),
        .DATA_W      (16),
        .STACK_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_out      (pc_out),
        .jump        (jump),
        .call        (call),
        .ret         (ret),
        .branch      (branch),
        .increment   (increment),
        .clr_err     (clr_err),
        .data        (data),
        .sp          (sp),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    // Reading pc onto the bus while also loading from it is a protocol error.
    always @(posedge clk) begin
        assert (!(pc_out && (jump || call || branch)))
            else $error("[TB] protocol violation: pc_out together with a bus load");
    end

    // Hard stop in case something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time=%0t limit=200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t mk_exp(input logic [7:0] pc, input logic [2:0] s,
                                    input logic f, input logic e,
                                    input logic o, input logic u);
        obs_t r;
        r.bus   = {8'h00, pc};
        r.sp    = s;
        r.full  = f;
        r.empty = e;
        r.ovf   = o;
        r.unf   = u;
        return r;
    endfunction

    function automatic step_t mk_step(input logic [6:0] ops, input logic [15:0] d,
                                      input obs_t e);
        step_t r;
        r.ops = ops;
        r.d   = d;
        r.e   = e;
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t r;
        r.bus   = data;
        r.sp    = sp;
        r.full  = stack_full;
        r.empty = stack_empty;
        r.ovf   = overflow;
        r.unf   = underflow;
        return r;
    endfunction

    // Drive one operation for one clock, then put pc on the bus for reading.
    task automatic applyStimulus(input logic [6:0] ops, input logic [15:0] d);
        @(negedge clk);
        pc_out   = 1'b0;
        tb_drive = 1'b1;
        tb_data  = d;
        {rst, jump, call, ret, branch, increment, clr_err} = ops;
        @(posedge clk);
        #1;
        {rst, jump, call, ret, branch, increment, clr_err} = S_NOP;
        tb_drive = 1'b0;
        pc_out   = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t e;
        sb.push_back(mk_exp(8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        applyStimulus(S_RST, 16'h0000);
        got = observe();
        e   = sb.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("[TB] FAIL reset: got=%h expected=%h", got, e);
        end
    endtask

    task automatic test_increment();
        obs_t got;
        obs_t e;
        for (int i = 0; i < 256; i++) begin
            sb.push_back(mk_exp(8'(i + 1), 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
            applyStimulus(S_INC, 16'h0000);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL increment[%0d]: got=%h expected=%h", i, got, e);
            end
            // With pc_out low the DUT must release the bus, so a bench-driven
            // zero must read back unchanged while pc is non-zero.
            if ((i % 64) == 63) begin
                pc_out   = 1'b0;
                tb_drive = 1'b1;
                tb_data  = 16'h0000;
                #1;
                checks++;
                if (data !== 16'h0000) begin
                    failures++;
                    $display("[TB] FAIL bus_release[%0d]: got=%h expected=0000", i, data);
                end
                tb_drive = 1'b0;
            end
        end
    endtask

    task automatic test_branch();
        step_t steps[$];
        obs_t  got;
        obs_t  e;
        steps.push_back(mk_step(S_JMP, 16'h0010, mk_exp(8'h10, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_BR,  16'h00FC, mk_exp(8'h0C, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_BR,  16'hFF05, mk_exp(8'h11, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        foreach (steps[k]) begin
            sb.push_back(steps[k].e);
            applyStimulus(steps[k].ops, steps[k].d);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL branch[%0d]: got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_call_ret();
        step_t steps[$];
        obs_t  got;
        obs_t  e;
        steps.push_back(mk_step(S_JMP, 16'h0020, mk_exp(8'h20, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_CAL, 16'h0040, mk_exp(8'h40, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_CAL, 16'h0060, mk_exp(8'h60, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET, 16'h0000, mk_exp(8'h41, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET, 16'h0000, mk_exp(8'h21, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        foreach (steps[k]) begin
            sb.push_back(steps[k].e);
            applyStimulus(steps[k].ops, steps[k].d);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL call_ret[%0d]: got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_overflow();
        step_t steps[$];
        obs_t  got;
        obs_t  e;
        steps.push_back(mk_step(S_CAL, 16'h0080, mk_exp(8'h80, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_CAL, 16'h0081, mk_exp(8'h81, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_CAL, 16'h0082, mk_exp(8'h82, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_CAL, 16'h0083, mk_exp(8'h83, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_CAL, 16'h0090, mk_exp(8'h83, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0)));
        steps.push_back(mk_step(S_CLR, 16'h0000, mk_exp(8'h83, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET, 16'h0000, mk_exp(8'h83, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET, 16'h0000, mk_exp(8'h82, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET, 16'h0000, mk_exp(8'h81, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET, 16'h0000, mk_exp(8'h22, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        foreach (steps[k]) begin
            sb.push_back(steps[k].e);
            applyStimulus(steps[k].ops, steps[k].d);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL overflow[%0d]: got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_underflow();
        step_t steps[$];
        obs_t  got;
        obs_t  e;
        steps.push_back(mk_step(S_RET,         16'h0000, mk_exp(8'h22, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1)));
        steps.push_back(mk_step(S_RET | S_CLR, 16'h0000, mk_exp(8'h22, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1)));
        steps.push_back(mk_step(S_CLR,         16'h0000, mk_exp(8'h22, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        foreach (steps[k]) begin
            sb.push_back(steps[k].e);
            applyStimulus(steps[k].ops, steps[k].d);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL underflow[%0d]: got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_priority();
        step_t steps[$];
        obs_t  got;
        obs_t  e;
        steps.push_back(mk_step(S_JMP | S_CAL | S_INC,         16'h0033, mk_exp(8'h33, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_CAL | S_RET | S_BR | S_INC,  16'h0050, mk_exp(8'h50, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET | S_BR | S_INC,          16'h0002, mk_exp(8'h34, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_BR | S_INC,                  16'h0002, mk_exp(8'h36, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET | S_INC,                 16'h0000, mk_exp(8'h36, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1)));
        foreach (steps[k]) begin
            sb.push_back(steps[k].e);
            applyStimulus(steps[k].ops, steps[k].d);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL priority[%0d]: got=%h expected=%h", k, got, e);
            end
        end
    endtask

    task automatic test_reset_override();
        step_t steps[$];
        obs_t  got;
        obs_t  e;
        steps.push_back(mk_step(S_CAL,         16'h0070, mk_exp(8'h70, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1)));
        steps.push_back(mk_step(S_CAL,         16'h0071, mk_exp(8'h71, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1)));
        steps.push_back(mk_step(S_RST | S_CAL, 16'h0099, mk_exp(8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        steps.push_back(mk_step(S_RET,         16'h0000, mk_exp(8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1)));
        steps.push_back(mk_step(S_RST | S_RET, 16'h0000, mk_exp(8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0)));
        foreach (steps[k]) begin
            sb.push_back(steps[k].e);
            applyStimulus(steps[k].ops, steps[k].d);
            got = observe();
            e   = sb.pop_front();
            checks++;
            if (got !== e) begin
                failures++;
                $display("[TB] FAIL reset_override[%0d]: got=%h expected=%h", k, got, e);
            end
        end
    endtask

    initial begin
        {rst, jump, call, ret, branch, increment, clr_err} = S_NOP;
        pc_out   = 1'b0;
        tb_drive = 1'b0;
        tb_data  = 16'h0000;

        test_reset();
        test_increment();
        test_branch();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_reset_override();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
